// File: rtl/seg7_digit_bank.sv
// Registered bank of 7-segment digit drivers: keypad digits shift in at position 0,
// unentered positions blank, optional dash masking and whole-display blink.
module seg7_digit_bank #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_HALF = 25000000,
  parameter bit          HEX_EN     = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 shift_en,
  input  logic [3:0]                           shift_val,
  input  logic                                 clr,
  input  logic                                 mask_en,
  input  logic                                 blink_en,
  output logic [4*NUM_DIGITS-1:0]              digits_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]      count,
  output logic                                 full,
  output logic [7*NUM_DIGITS-1:0]              seg_out
);

  localparam int unsigned CntW   = $clog2(NUM_DIGITS + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF);

  localparam logic [CntW-1:0]   CountMax = CntW'(NUM_DIGITS);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF - 1);

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [CntW-1:0]         r_count;
  logic [BlinkW-1:0]       r_blink_cnt;
  logic                    r_phase_on;
  logic [7*NUM_DIGITS-1:0] r_seg;

  logic [4*NUM_DIGITS-1:0] w_digits_shifted;
  logic [7*NUM_DIGITS-1:0] w_seg_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] code;
    code = 7'b1111111;
    case (val)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = HEX_EN ? 7'b0001000 : 7'b1111111;
      4'hB: code = HEX_EN ? 7'b0000011 : 7'b1111111;
      4'hC: code = HEX_EN ? 7'b1000110 : 7'b1111111;
      4'hD: code = HEX_EN ? 7'b0100001 : 7'b1111111;
      4'hE: code = HEX_EN ? 7'b0000110 : 7'b1111111;
      4'hF: code = HEX_EN ? 7'b0001110 : 7'b1111111;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  // Shift left by one digit; the oldest digit falls off the top.
  always_comb begin
    w_digits_shifted      = r_digits << 4;
    w_digits_shifted[3:0] = shift_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_digits <= '0;
      r_count  <= '0;
    end else if (shift_en) begin
      r_digits <= w_digits_shifted;
      if (r_count != CountMax) begin
        r_count <= r_count + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      r_blink_cnt <= '0;
      r_phase_on  <= 1'b1;
    end else if (r_blink_cnt == BlinkMax) begin
      r_blink_cnt <= '0;
      r_phase_on  <= ~r_phase_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BlinkW'(1);
    end
  end

  // Priority: blink-off, not yet entered, dash mask, value decode.
  always_comb begin
    w_seg_d = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (!r_phase_on || (i >= int'(r_count))) begin
        w_seg_d[7*i +: 7] = 7'b1111111;
      end else if (mask_en) begin
        w_seg_d[7*i +: 7] = 7'b0111111;
      end else begin
        w_seg_d[7*i +: 7] = seg_decode(r_digits[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= '1;
    end else begin
      r_seg <= w_seg_d;
    end
  end

  assign digits_out = r_digits;
  assign count      = r_count;
  assign full       = (r_count == CountMax);
  assign seg_out    = r_seg;

endmodule

// File: tb/tb_seg7_digit_bank.sv
// Directed bench for seg7_digit_bank: two instances (hex on/off) share the stimulus.
module tb_seg7_digit_bank;

  logic        clk;
  logic        rst;
  logic        shift_en;
  logic [3:0]  shift_val;
  logic        clr;
  logic        mask_en;
  logic        blink_en;

  logic [15:0] digits_h;
  logic [2:0]  count_h;
  logic        full_h;
  logic [27:0] seg_h;

  logic [15:0] digits_n;
  logic [2:0]  count_n;
  logic        full_n;
  logic [27:0] seg_n;

  int n_pass;
  int n_total;

  localparam logic [6:0] Blank = 7'b1111111;
  localparam logic [6:0] Dash  = 7'b0111111;

  seg7_digit_bank #(
    .NUM_DIGITS(4),
    .BLINK_HALF(4),
    .HEX_EN    (1'b1)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .shift_val (shift_val),
    .clr       (clr),
    .mask_en   (mask_en),
    .blink_en  (blink_en),
    .digits_out(digits_h),
    .count     (count_h),
    .full      (full_h),
    .seg_out   (seg_h)
  );

  seg7_digit_bank #(
    .NUM_DIGITS(4),
    .BLINK_HALF(4),
    .HEX_EN    (1'b0)
  ) u_dut_nohex (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .shift_val (shift_val),
    .clr       (clr),
    .mask_en   (mask_en),
    .blink_en  (blink_en),
    .digits_out(digits_n),
    .count     (count_n),
    .full      (full_n),
    .seg_out   (seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic shift_in(input logic [3:0] v);
    shift_en  = 1'b1;
    shift_val = v;
    tick(1);
    shift_en  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    shift_en  = 1'b0;
    shift_val = 4'h0;
    clr       = 1'b0;
    mask_en   = 1'b0;
    blink_en  = 1'b0;
    tick(2);
    rst = 1'b0;

    check("reset_seg", 32'(seg_h), 32'h0FFF_FFFF);
    check("reset_count", 32'(count_h), 32'd0);
    check("reset_full", 32'(full_h), 32'd0);
    check("reset_digits", 32'(digits_h), 32'h0);
    tick(10);
    check("idle_seg", 32'(seg_h), 32'h0FFF_FFFF);
    check("idle_count", 32'(count_h), 32'd0);

    // Entry of 1,2,3: digit 3 stays blank
    shift_in(4'h1);
    shift_in(4'h2);
    shift_in(4'h3);
    check("entry_digits", 32'(digits_h), 32'h0123);
    check("entry_count", 32'(count_h), 32'd3);
    check("entry_full", 32'(full_h), 32'd0);
    tick(1);
    check("entry_seg", 32'(seg_h), 32'({Blank, 7'b1111001, 7'b0100100, 7'b0110000}));

    // Overflow
    pulse_clr();
    shift_in(4'h1);
    shift_in(4'h2);
    shift_in(4'h3);
    shift_in(4'h4);
    shift_in(4'h5);
    check("ovf_digits", 32'(digits_h), 32'h2345);
    check("ovf_count", 32'(count_h), 32'd4);
    check("ovf_full", 32'(full_h), 32'd1);
    tick(1);
    check("ovf_seg", 32'(seg_h), 32'({7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}));

    // Mask
    mask_en = 1'b1;
    tick(1);
    check("mask_seg", 32'(seg_h), 32'({Dash, Dash, Dash, Dash}));

    // clr wins over shift
    clr       = 1'b1;
    shift_en  = 1'b1;
    shift_val = 4'h9;
    tick(1);
    clr       = 1'b0;
    shift_en  = 1'b0;
    check("clr_count", 32'(count_h), 32'd0);
    check("clr_digits", 32'(digits_h), 32'h0);
    check("clr_full", 32'(full_h), 32'd0);
    tick(1);
    check("clr_seg", 32'(seg_h), 32'h0FFF_FFFF);
    mask_en = 1'b0;

    // Blink with two digits entered
    shift_in(4'h1);
    shift_in(4'h2);
    tick(1);
    check("pre_blink_seg", 32'(seg_h), 32'({Blank, Blank, 7'b1111001, 7'b0100100}));
    blink_en = 1'b1;
    tick(4);
    check("blink_edge4_on", 32'(seg_h), 32'({Blank, Blank, 7'b1111001, 7'b0100100}));
    tick(1);
    check("blink_edge5_off", 32'(seg_h), 32'h0FFF_FFFF);
    tick(3);
    check("blink_edge8_off", 32'(seg_h), 32'h0FFF_FFFF);
    tick(1);
    check("blink_edge9_on", 32'(seg_h), 32'({Blank, Blank, 7'b1111001, 7'b0100100}));
    tick(4);
    check("blink_edge13_off", 32'(seg_h), 32'h0FFF_FFFF);
    blink_en = 1'b0;
    tick(2);
    check("blink_drop_on", 32'(seg_h), 32'({Blank, Blank, 7'b1111001, 7'b0100100}));

    // Hex vs no-hex decode of 4'hB
    pulse_clr();
    shift_in(4'hB);
    tick(1);
    check("hex_on_seg", 32'(seg_h), 32'({Blank, Blank, Blank, 7'b0000011}));
    check("hex_off_seg", 32'(seg_n), 32'h0FFF_FFFF);
    check("hex_off_digits", 32'(digits_n), 32'h000B);

    // Digit 0 and 8 decode
    shift_in(4'h0);
    shift_in(4'h8);
    tick(1);
    check("dec_0_8_seg", 32'(seg_h), 32'({Blank, 7'b0000011, 7'b1000000, 7'b0000000}));

    // Reset mid-blink with shift_en high
    blink_en = 1'b1;
    tick(5);
    check("pre_rst_off", 32'(seg_h), 32'h0FFF_FFFF);
    rst       = 1'b1;
    shift_en  = 1'b1;
    shift_val = 4'h7;
    tick(1);
    rst       = 1'b0;
    shift_en  = 1'b0;
    blink_en  = 1'b0;
    check("rst_digits", 32'(digits_h), 32'h0);
    check("rst_count", 32'(count_h), 32'd0);
    check("rst_full", 32'(full_h), 32'd0);
    check("rst_seg", 32'(seg_h), 32'h0FFF_FFFF);
    check("rst_nohex_count", 32'(count_n), 32'd0);
    check("rst_nohex_full", 32'(full_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
